uart_tx_fifo_param: RTL

Parametrised successor to the fixed 8-bit UART transmitter controller. It buffers bytes in a small FIFO and serialises them with a programmable data width, parity, stop-bit count and bit order. A clock-enable baud tick generator replaces the derived bit clock, so all logic runs on clk_in. It sits between board/CPU-side data sources and the ser_out pin, alongside the existing receiver.

---
 rtl/uart_tx_fifo_param.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with a small word FIFO, per-frame latched line settings and
// a clock-enable baud counter. All logic runs on clk_in.
module uart_tx_fifo_param #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1,
    parameter int DIV0       = 868,
    parameter int DIV1       = 1736,
    parameter int DIV2       = 5208,
    parameter int DIV3       = 10417
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic [1:0]                    baud_sel,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          ser_out,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CW      = PTR_W + 1;
    localparam int M01     = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int M23     = (DIV2 > DIV3) ? DIV2 : DIV3;
    localparam int DIV_MAX = (M01 > M23) ? M01 : M23;
    localparam int CNT_W   = (DIV_MAX < 2) ? 1 : $clog2(DIV_MAX);
    localparam int BIT_W   = (DATA_BITS < 2) ? 1 : $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     div_q;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic                 par_en_q;
    logic                 two_stop_q;
    logic                 push;
    logic                 pop;
    logic                 tick;
    logic                 last_stop;
    logic                 last_data;
    logic                 data_bit;
    logic                 shift_en;

    function automatic logic [CNT_W-1:0] div_m1(input logic [1:0] sel);
        logic [CNT_W-1:0] d;
        case (sel)
            2'd0:    d = CNT_W'(DIV0 - 1);
            2'd1:    d = CNT_W'(DIV1 - 1);
            2'd2:    d = CNT_W'(DIV2 - 1);
            default: d = CNT_W'(DIV3 - 1);
        endcase
        return d;
    endfunction

    assign tx_ready  = (fifo_count < CW'(FIFO_DEPTH));
    assign push      = tx_valid && tx_ready;
    assign tick      = (cnt == '0);
    assign last_stop = !two_stop_q || stop_idx;
    assign last_data = (bit_idx == BIT_W'(DATA_BITS - 1));
    // A new frame starts from IDLE or straight out of the final stop boundary.
    assign pop       = (fifo_count != '0) &&
                       ((state == IDLE) || ((state == STOP) && tick && last_stop));
    assign shift_en  = tick && ((state == START) || ((state == DATA) && !last_data));
    assign data_bit  = (MSB_FIRST != 0) ? shreg[DATA_BITS-1] : shreg[0];

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // The output bit is taken from the head of shreg before each shift.
    always_ff @(posedge clk_in) begin
        if (pop) begin
            shreg   <= mem[rd_ptr];
            par_bit <= (^mem[rd_ptr]) ^ (parity_mode == 2'd2);
        end else if (shift_en) begin
            shreg <= (MSB_FIRST != 0) ? {shreg[DATA_BITS-2:0], 1'b0}
                                      : {1'b0, shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ser_out    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= '0;
            div_q      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!tick) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (pop) begin
                state      <= START;
                ser_out    <= 1'b0;
                busy       <= 1'b1;
                cnt        <= div_m1(baud_sel);
                div_q      <= div_m1(baud_sel);
                par_en_q   <= parity_mode[0] ^ parity_mode[1];
                two_stop_q <= two_stop;
            end else begin
                case (state)
                    IDLE: begin
                        ser_out <= 1'b1;
                        busy    <= 1'b0;
                    end
                    START: begin
                        if (tick) begin
                            cnt     <= div_q;
                            ser_out <= data_bit;
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            cnt <= div_q;
                            if (!last_data) begin
                                bit_idx <= bit_idx + BIT_W'(1);
                                ser_out <= data_bit;
                            end else if (par_en_q) begin
                                ser_out <= par_bit;
                                state   <= PARITY;
                            end else begin
                                ser_out    <= 1'b1;
                                stop_idx   <= 1'b0;
                                frame_done <= (div_q == '0) && !two_stop_q;
                                state      <= STOP;
                            end
                        end
                    end
                    PARITY: begin
                        if (tick) begin
                            cnt        <= div_q;
                            ser_out    <= 1'b1;
                            stop_idx   <= 1'b0;
                            frame_done <= (div_q == '0) && !two_stop_q;
                            state      <= STOP;
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            if (last_stop) begin
                                ser_out <= 1'b1;
                                busy    <= 1'b0;
                                state   <= IDLE;
                            end else begin
                                stop_idx   <= 1'b1;
                                cnt        <= div_q;
                                frame_done <= (div_q == '0);
                            end
                        end else if (last_stop && (cnt == CNT_W'(1))) begin
                            // Raised so the pulse covers the final cycle of the last stop bit.
                            frame_done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
